// File: rtl/ret_sbc_mc.sv
// Multi-channel stochastic-to-binary converter with early termination.
// Counts ones on NCH parallel bitstreams over a shared window, then rescales each count to a
// WIDTH-bit estimate. The window ends on the external done request or after 2^et_log2 bits.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   start       single-cycle pulse: clears counters, latches et_log2, opens a window
//   pz          one stochastic bit per channel per cycle (bit i -> channel i)
//   done        external early-termination request (honoured only while counting)
//   et_log2     auto-termination length exponent, clamped to WIDTH, sampled on start
//   Bz          scaled results, channel i at [i*WIDTH +: WIDTH]
//   done_p2     result valid, held until the next start
//   busy        high while counting or scaling
module ret_sbc_mc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NCH-1:0]       pz,
  input  logic                 done,
  input  logic [LW-1:0]        et_log2,
  output logic [NCH*WIDTH-1:0] Bz,
  output logic                 done_p2,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StCount, StScale, StHold} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH:0]          ctr_q, ctr_d;
  logic [NCH-1:0][WIDTH:0] sum_q, sum_d;
  logic [LW-1:0]           etl_q, etl_d;
  logic [LW-1:0]           k_q, k_d;
  logic                    eq_q, eq_d;
  logic                    ph_q, ph_d;
  logic [NCH*WIDTH-1:0]    bz_q, bz_d;

  logic [LW-1:0]           etl_clamp;
  logic [WIDTH:0]          ctr_inc;
  logic [WIDTH:0]          lim;
  logic                    term;
  logic [LW-1:0]           msb_idx;
  logic                    pow2;
  logic [LW-1:0]           shamt;
  logic [2*WIDTH:0]        wide;
  logic [NCH*WIDTH-1:0]    bz_scaled;

  // Flags that the estimate used the floor power of two (upward bias) when low.
  logic                    eq;
  assign eq = eq_q;

  assign etl_clamp = (et_log2 > LW'(WIDTH)) ? LW'(WIDTH) : et_log2;
  assign ctr_inc   = ctr_q + (WIDTH + 1)'(1);
  assign lim       = (WIDTH + 1)'(1) << etl_q;
  assign term      = done || (ctr_inc == lim);
  assign pow2      = ~|(ctr_q & (ctr_q - (WIDTH + 1)'(1)));
  assign shamt     = LW'(WIDTH) - k_q;

  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 0; i < WIDTH + 1; i++) begin
      if (ctr_q[i]) msb_idx = LW'(i);
    end
  end

  // sum fits WIDTH+1 bits and shift is at most WIDTH, so 2*WIDTH+1 bits never overflow.
  always_comb begin
    wide      = '0;
    bz_scaled = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      wide = {{WIDTH{1'b0}}, sum_q[c]} << shamt;
      bz_scaled[c*WIDTH +: WIDTH] = (|wide[2*WIDTH:WIDTH]) ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    sum_d   = sum_q;
    etl_d   = etl_q;
    k_d     = k_q;
    eq_d    = eq_q;
    ph_d    = ph_q;
    bz_d    = bz_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (start) begin
          state_d = StCount;
          ctr_d   = '0;
          sum_d   = '0;
          etl_d   = etl_clamp;
        end
      end
      StCount: begin
        if (start) begin
          // Restart: this edge's bit is discarded along with the old window.
          ctr_d = '0;
          sum_d = '0;
          etl_d = etl_clamp;
        end else begin
          ctr_d = ctr_inc;
          for (int unsigned c = 0; c < NCH; c++) begin
            sum_d[c] = sum_q[c] + {{WIDTH{1'b0}}, pz[c]};
          end
          if (term) state_d = StScale;
        end
      end
      StScale: begin
        // Two cycles: first register k/eq, then apply the shift into Bz.
        if (!ph_q) begin
          k_d  = msb_idx;
          eq_d = pow2;
          ph_d = 1'b1;
        end else begin
          bz_d    = bz_scaled;
          ph_d    = 1'b0;
          state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      sum_q   <= '0;
      etl_q   <= '0;
      k_q     <= '0;
      eq_q    <= 1'b0;
      ph_q    <= 1'b0;
      bz_q    <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      sum_q   <= sum_d;
      etl_q   <= etl_d;
      k_q     <= k_d;
      eq_q    <= eq_d;
      ph_q    <= ph_d;
      bz_q    <= bz_d;
    end
  end

  assign Bz      = bz_q;
  assign done_p2 = (state_q == StHold);
  assign busy    = (state_q == StCount) || (state_q == StScale);

endmodule

// File: tb/tb_ret_sbc_mc.sv
module tb_ret_sbc_mc;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 4;
  localparam int unsigned LW    = $clog2(WIDTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [NCH-1:0]       pz;
  logic                 done;
  logic [LW-1:0]        et_log2;
  logic [NCH*WIDTH-1:0] Bz;
  logic                 done_p2;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  logic [NCH*WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  ret_sbc_mc #(.WIDTH(WIDTH), .NCH(NCH)) uut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pz      (pz),
    .done    (done),
    .et_log2 (et_log2),
    .Bz      (Bz),
    .done_p2 (done_p2),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic drive(input logic [3:0] p, input logic d, input logic s);
    pz    = p;
    done  = d;
    start = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    done  = 1'b0;
  endtask

  function automatic logic [3:0] pz_at(input int mode, input int i);
    case (mode)
      0:       return {(i % 4) == 0, 1'b0, 1'b1, (i % 2) == 0};
      1:       return {3'b000, i < 5};
      2:       return {2'b00, 1'b1, i < 6};
      default: return 4'b0000;
    endcase
  endfunction

  // Called right after the termination edge: done_p2 must rise exactly two edges later.
  task automatic finish_check(input string tag);
    logic [NCH*WIDTH-1:0] exp;
    check({tag, "_T_done_p2"}, {31'b0, done_p2}, 32'd0);
    check({tag, "_T_busy"}, {31'b0, busy}, 32'd1);
    drive(4'b0000, 1'b0, 1'b0);
    check({tag, "_T1_done_p2"}, {31'b0, done_p2}, 32'd0);
    drive(4'b0000, 1'b0, 1'b0);
    check({tag, "_T2_done_p2"}, {31'b0, done_p2}, 32'd1);
    check({tag, "_T2_busy"}, {31'b0, busy}, 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_Bz"}, Bz, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    pz      = '0;
    done    = 1'b0;
    et_log2 = '0;
    #3;
    check("rst_Bz", Bz, 32'd0);
    check("rst_done_p2", {31'b0, done_p2}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_eq", {31'b0, uut.eq}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // done in IDLE has no effect
    for (int i = 0; i < 3; i++) drive(4'b1111, 1'b1, 1'b0);
    check("idle_done_busy", {31'b0, busy}, 32'd0);
    check("idle_done_p2", {31'b0, done_p2}, 32'd0);

    // Full-length window, mixed patterns
    et_log2 = 4'd8;
    drive(4'b0000, 1'b0, 1'b1);
    check("t1_busy_start", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) exp_q.push_back(32'h4000FF80);
      drive(pz_at(0, i), 1'b0, 1'b0);
    end
    finish_check("t1");
    check("t1_eq", {31'b0, uut.eq}, 32'd1);

    // Auto-termination at 16 bits; start from HOLD drops done_p2 on that edge
    et_log2 = 4'd4;
    drive(4'b0000, 1'b0, 1'b1);
    check("t2_start_drop_done_p2", {31'b0, done_p2}, 32'd0);
    check("t2_Bz_kept", Bz, 32'h4000FF80);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(32'h00000050);
      drive(pz_at(1, i), 1'b0, 1'b0);
    end
    finish_check("t2");
    check("t2_eq", {31'b0, uut.eq}, 32'd1);
    for (int i = 0; i < 5; i++) drive(4'b1111, 1'b1, 1'b0);
    check("t2_hold_Bz", Bz, 32'h00000050);
    check("t2_hold_done_p2", {31'b0, done_p2}, 32'd1);

    // External done on bit 12, non-power-of-two count
    et_log2 = 4'd8;
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i == 11) exp_q.push_back(32'h0000FFC0);
      drive(pz_at(2, i), i == 11, 1'b0);
    end
    finish_check("t3");
    check("t3_eq", {31'b0, uut.eq}, 32'd0);

    // One-bit window
    et_log2 = 4'd0;
    drive(4'b0000, 1'b0, 1'b1);
    exp_q.push_back(32'h00FF00FF);
    drive(4'b0101, 1'b0, 1'b0);
    finish_check("t4a");

    // et_log2 above WIDTH clamps to a full window
    et_log2 = 4'd15;
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) exp_q.push_back(32'h0000FFFF);
      drive(4'b0011, 1'b0, 1'b0);
    end
    finish_check("t4b");

    // done on the same edge as the length limit: a single result
    et_log2 = 4'd2;
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(32'hFF000000);
      drive(4'b1000, i == 3, 1'b0);
    end
    finish_check("t6_coll");
    for (int i = 0; i < 4; i++) drive(4'b0000, 1'b1, 1'b0);
    check("t6_hold_done_Bz", Bz, 32'hFF000000);
    check("t6_hold_done_p2", {31'b0, done_p2}, 32'd1);
    check("t6_single_result", exp_q.size(), 32'd0);

    // start mid-COUNT restarts without producing a result
    et_log2 = 4'd3;
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b1);
    check("t6_restart_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(32'h00000040);
      else check("t6_restart_no_done_p2", {31'b0, done_p2}, 32'd0);
      drive((i < 2) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
    end
    finish_check("t6_restart");

    // Asynchronous reset mid-window
    et_log2 = 4'd8;
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) drive(4'b1111, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_Bz", Bz, 32'd0);
    check("t5_rst_done_p2", {31'b0, done_p2}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive((i % 2) ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
    check("t5_post_Bz", Bz, 32'd0);
    check("t5_post_done_p2", {31'b0, done_p2}, 32'd0);
    check("t5_post_busy", {31'b0, busy}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ret_sbc_mc.md
Name: ret_sbc_mc

Overview:
- Multi-channel stochastic-to-binary converter with early termination.
- Counts ones on NCH parallel stochastic bitstreams over one shared window, then rescales each count to a WIDTH-bit binary estimate.
- The window ends by the external `done` input or by a runtime-programmed power-of-two length.
- Sits at the output of the SC datapath and replaces single-channel, externally-terminated-only counters.

Parameters:
- WIDTH, 8, output precision; full stream length is 2^WIDTH bits.
- NCH, 4, number of independent bitstream channels.
- LW, $clog2(WIDTH+1), width of the et_log2 port (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; clears counters and opens a window.
- pz  input  NCH  one stochastic bit per channel per cycle; bit i belongs to channel i.
- done  input  1  external early-termination request.
- et_log2  input  LW  auto-termination length exponent; window length is 2^et_log2; values above WIDTH clamp to WIDTH. Sampled on start.
- Bz  output  NCH*WIDTH  scaled results; channel i occupies bits [i*WIDTH +: WIDTH].
- done_p2  output  1  result valid; stays high until the next start.
- busy  output  1  high while in COUNT or SCALE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - ctr (WIDTH+1 bits), per-channel sum (WIDTH+1 bits) and the latched et_log2 all cleared to 0.
  - Bz=0, done_p2=0, busy=0.
  - Reset mid-window abandons the window with no output; pz is ignored until the next start.
- States: IDLE, COUNT, SCALE, HOLD.
- IDLE:
  - start -> COUNT; clear ctr and sums; latch clamped et_log2.
  - done and pz are ignored.
- COUNT (edge that samples a bit):
  - sum[i] += pz[i] for every channel; ctr += 1.
  - Termination edge T is the first edge where done=1, or where ctr+1 == 2^et_log2. The bit sampled on edge T is included.
  - Both conditions on the same edge produce a single termination.
  - T -> SCALE.
  - start during COUNT restarts the window: counters cleared, et_log2 re-latched, stay in COUNT, no result produced.
- SCALE (edge T+1):
  - Register k = index of the MSB of ctr (range 0..WIDTH).
  - Register eq = (ctr is a power of two).
  - -> HOLD.
- HOLD entry (edge T+2):
  - Bz[i] = min(sum[i] << (WIDTH-k), 2^WIDTH-1), i.e. saturated.
  - done_p2 rises. Latency from termination edge to done_p2 is exactly 2 cycles.
  - When eq=0, the estimate uses the floor power of two (biased upward). This is intended and is recorded in an internal flag readable by the bench as uut.eq.
- HOLD:
  - Bz and done_p2 hold.
  - start -> COUNT; done_p2 falls on that same edge; Bz keeps its old value until the next result.
  - done is ignored.
- Arithmetic:
  - Full-length window: ctr reaches 2^WIDTH, so k=WIDTH and shift=0.
  - A sum of 2^WIDTH saturates Bz to all ones.
  - et_log2=0 gives a 1-bit window: Bz = pz ? 2^WIDTH-1 : 0.
- Channels are fully independent except for the shared ctr and termination.
- busy = (state==COUNT) || (state==SCALE).

Test Plan:
1. WIDTH=8, NCH=4, et_log2=8; ch0 alternating 1/0, ch1 all 1, ch2 all 0, ch3 one-in-four; start then 256 bits -> Bz = {64, 0, 255, 128} (ch3..ch0); done_p2 high exactly 2 cycles after the 256th bit edge; busy low thereafter.
2. et_log2=4, ch0 carries five 1s in 16 bits -> auto-termination at the 16th bit; Bz[ch0]=80; eq=1; done_p2 at T+2; later pz activity leaves Bz unchanged.
3. et_log2=8, external done on the edge sampling bit 12; ch0 sum=6 -> k=3, eq=0, Bz[ch0]=192; ch1 sum=12 -> Bz[ch1]=255 (saturated).
4. et_log2=0: pz=4'b0101 -> Bz = {0, 255, 0, 255}. Also et_log2=15 behaves as 8.
5. rst_n low at bit 50 of a window -> Bz, done_p2, busy go to 0 immediately (asynchronous); after release, pz toggling without start leaves the outputs at 0.
6. Event collisions:
   - done asserted on the same edge as the 2^et_log2 limit -> one termination, one result.
   - done asserted in IDLE or HOLD -> no effect.
   - start in HOLD -> done_p2 drops on that edge and a new window begins.
   - start mid-COUNT -> window restarts with no done_p2 pulse.
